// File: rtl/health_controller.sv
// Player health state machine: owns present_health, applies hits with
// post-hit invulnerability, heal pickups, slow regeneration and game over.
module health_controller #(
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int REGEN_FRAMES  = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       heal,
  input  logic       restart,
  output logic [3:0] present_health,
  output logic       invuln,
  output logic       blink,
  output logic       hit_ack,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  localparam logic [3:0] HEALTH_MAX = 4'(MAX_HEALTH);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);
  localparam logic [9:0] REGEN_LAST = 10'(REGEN_FRAMES - 1);

  state_e     state_q, state_d;
  logic [3:0] health_q, health_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic [9:0] regen_cnt_q, regen_cnt_d;
  logic       hit_ack_q, hit_ack_d;
  logic       invuln_q, invuln_d;
  logic       game_over_q, game_over_d;
  logic       grow;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    state_d     = state_q;
    health_d    = health_q;
    inv_cnt_d   = inv_cnt_q;
    regen_cnt_d = regen_cnt_q;
    hit_ack_d   = 1'b0;
    grow        = 1'b0;

    unique case (state_q)
      ST_ALIVE: begin
        if (hit) begin
          hit_ack_d   = 1'b1;
          regen_cnt_d = '0;
          if (health_q <= 4'd1) begin
            state_d   = ST_DEAD;
            health_d  = '0;
            inv_cnt_d = '0;
          end else begin
            state_d   = ST_INVULN;
            health_d  = health_q - 4'd1;
            inv_cnt_d = INV_LOAD;
          end
        end else begin
          grow = heal;
          if (frame_tick) begin
            // The counter wraps even at full health; only the +1 saturates.
            if (regen_cnt_q == REGEN_LAST) begin
              regen_cnt_d = '0;
              grow        = 1'b1;
            end else begin
              regen_cnt_d = regen_cnt_q + 10'd1;
            end
          end
          if (grow && health_q < HEALTH_MAX) health_d = health_q + 4'd1;
        end
      end

      ST_INVULN: begin
        regen_cnt_d = '0;
        if (heal && health_q < HEALTH_MAX) health_d = health_q + 4'd1;
        if (frame_tick) begin
          if (inv_cnt_q <= 8'd1) begin
            state_d   = ST_ALIVE;
            inv_cnt_d = '0;
          end else begin
            inv_cnt_d = inv_cnt_q - 8'd1;
          end
        end
      end

      ST_DEAD: begin
        if (restart) begin
          state_d     = ST_ALIVE;
          health_d    = HEALTH_MAX;
          inv_cnt_d   = '0;
          regen_cnt_d = '0;
        end
      end

      default: begin
        state_d     = ST_ALIVE;
        health_d    = HEALTH_MAX;
        inv_cnt_d   = '0;
        regen_cnt_d = '0;
      end
    endcase

    invuln_d    = (state_d == ST_INVULN);
    game_over_d = (state_d == ST_DEAD);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ALIVE;
      health_q    <= HEALTH_MAX;
      inv_cnt_q   <= '0;
      regen_cnt_q <= '0;
      hit_ack_q   <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      health_q    <= health_d;
      inv_cnt_q   <= inv_cnt_d;
      regen_cnt_q <= regen_cnt_d;
      hit_ack_q   <= hit_ack_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign present_health = health_q;
  assign invuln         = invuln_q;
  assign blink          = inv_cnt_q[3];
  assign hit_ack        = hit_ack_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_health_controller.sv
// Bench for health_controller: directed scenarios plus random stimulus, with
// a default instance and a short-timer instance both checked against a model.
module tb_health_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic hit = 1'b0;
  logic heal = 1'b0;
  logic restart = 1'b0;

  logic [1:0][3:0] dut_health;
  logic [1:0]      dut_invuln;
  logic [1:0]      dut_blink;
  logic [1:0]      dut_ack;
  logic [1:0]      dut_over;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance.
  localparam int MAXH = 3;
  int p_inv   [2] = '{60, 2};
  int p_regen [2] = '{600, 3};
  int m_health[2];
  int m_left  [2];   // invulnerable frames still to run; 0 = not invulnerable
  int m_regen [2];
  bit m_dead  [2];
  bit m_ack   [2];

  always #5 clk = ~clk;

  health_controller u_dut0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hit(hit), .heal(heal),
    .restart(restart), .present_health(dut_health[0]), .invuln(dut_invuln[0]),
    .blink(dut_blink[0]), .hit_ack(dut_ack[0]), .game_over(dut_over[0])
  );

  health_controller #(.INVULN_FRAMES(2), .REGEN_FRAMES(3)) u_dut1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hit(hit), .heal(heal),
    .restart(restart), .present_health(dut_health[1]), .invuln(dut_invuln[1]),
    .blink(dut_blink[1]), .hit_ack(dut_ack[1]), .game_over(dut_over[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_restart(input int i);
    m_health[i] = MAXH;
    m_left[i]   = 0;
    m_regen[i]  = 0;
    m_dead[i]   = 1'b0;
    m_ack[i]    = 1'b0;
  endfunction

  function automatic void model_update(input int i, input bit h, input bit he,
                                       input bit t, input bit rs, input bit rn);
    bit gain;
    m_ack[i] = 1'b0;
    if (!rn) begin
      model_restart(i);
    end else if (m_dead[i]) begin
      if (rs) model_restart(i);
    end else if (m_left[i] > 0) begin
      if (he) m_health[i] = (m_health[i] + 1 > MAXH) ? MAXH : m_health[i] + 1;
      if (t) m_left[i] = m_left[i] - 1;
    end else if (h) begin
      m_ack[i]    = 1'b1;
      m_health[i] = m_health[i] - 1;
      m_regen[i]  = 0;
      if (m_health[i] == 0) m_dead[i] = 1'b1;
      else                  m_left[i] = p_inv[i];
    end else begin
      gain = he;
      if (t) begin
        m_regen[i] = m_regen[i] + 1;
        if (m_regen[i] == p_regen[i]) begin
          m_regen[i] = 0;
          gain = 1'b1;
        end
      end
      if (gain) m_health[i] = (m_health[i] + 1 > MAXH) ? MAXH : m_health[i] + 1;
    end
  endfunction

  task automatic step(input bit h, input bit he, input bit t, input bit rs, input bit rn);
    hit = h; heal = he; frame_tick = t; restart = rs; rst = rn;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      model_update(i, h, he, t, rs, rn);
      check($sformatf("model_health%0d", i), int'(dut_health[i]), m_health[i]);
      check($sformatf("model_invuln%0d", i), int'(dut_invuln[i]), int'(m_left[i] > 0));
      check($sformatf("model_ack%0d", i), int'(dut_ack[i]), int'(m_ack[i]));
      check($sformatf("model_over%0d", i), int'(dut_over[i]), int'(m_dead[i]));
      if (m_left[i] > 0)
        check($sformatf("model_blink%0d", i), int'(dut_blink[i]), (m_left[i] >> 3) & 1);
    end
  endtask

  task automatic idle();                 step(0, 0, 0, 0, 1); endtask
  task automatic do_reset();             step(0, 0, 0, 0, 0); endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 0, 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_health", int'(dut_health[0]), 3);
    check("rst_invuln", int'(dut_invuln[0]), 0);
    check("rst_over", int'(dut_over[0]), 0);
    check("rst_ack", int'(dut_ack[0]), 0);
    idle();

    // 1: hit (with a coincident tick that must not count), then 60 ticks
    step(1, 0, 1, 0, 1);
    check("s1_health", int'(dut_health[0]), 2);
    check("s1_ack", int'(dut_ack[0]), 1);
    check("s1_invuln", int'(dut_invuln[0]), 1);
    idle();
    check("s1_ack_single", int'(dut_ack[0]), 0);

    // 2: hits during invulnerability are ignored
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 1);
      check("s2_health_hold", int'(dut_health[0]), 2);
      check("s2_no_ack", int'(dut_ack[0]), 0);
    end
    ticks(59);
    check("s1_invuln_59", int'(dut_invuln[0]), 1);
    ticks(1);
    check("s1_invuln_60", int'(dut_invuln[0]), 0);
    step(1, 0, 0, 0, 1);
    check("s2_health_after", int'(dut_health[0]), 1);
    check("s2_ack_after", int'(dut_ack[0]), 1);

    // 3: fatal hit, DEAD ignores inputs, restart
    ticks(60);
    step(1, 0, 0, 0, 1);
    check("s3_health0", int'(dut_health[0]), 0);
    check("s3_over", int'(dut_over[0]), 1);
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    check("s3_dead_health", int'(dut_health[0]), 0);
    check("s3_dead_over", int'(dut_over[0]), 1);
    check("s3_dead_ack", int'(dut_ack[0]), 0);
    step(0, 0, 0, 1, 1);
    check("s3_restart_health", int'(dut_health[0]), 3);
    check("s3_restart_over", int'(dut_over[0]), 0);

    // 4: hit+heal together, then heal saturation
    step(1, 0, 0, 0, 1);
    ticks(60);
    step(1, 1, 0, 0, 1);
    check("s4_hitheal_health", int'(dut_health[0]), 1);
    check("s4_hitheal_invuln", int'(dut_invuln[0]), 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    check("s4_heal_sat", int'(dut_health[0]), 3);

    // 5: regeneration on the short-timer instance
    do_reset();
    step(1, 0, 0, 0, 1);
    check("s5_hit", int'(dut_health[1]), 2);
    ticks(2);
    check("s5_invuln_end", int'(dut_invuln[1]), 0);
    ticks(2);
    check("s5_regen_pending", int'(dut_health[1]), 2);
    ticks(1);
    check("s5_regen", int'(dut_health[1]), 3);
    step(1, 0, 0, 0, 1);
    ticks(4);
    step(1, 0, 0, 0, 1);
    check("s5_second_hit", int'(dut_health[1]), 1);
    ticks(3);
    check("s5_regen_cleared", int'(dut_health[1]), 1);
    ticks(2);
    check("s5_regen_again", int'(dut_health[1]), 2);

    // 6: reset mid-INVULN and mid-DEAD
    do_reset();
    step(1, 0, 0, 0, 1);
    ticks(30);
    check("s6_blink_mid", int'(dut_blink[0]), 1);
    check("s6_invuln_mid", int'(dut_invuln[0]), 1);
    do_reset();
    check("s6_inv_health", int'(dut_health[0]), 3);
    check("s6_inv_invuln", int'(dut_invuln[0]), 0);
    check("s6_inv_blink", int'(dut_blink[0]), 0);
    step(1, 0, 0, 0, 1);
    ticks(60);
    step(1, 0, 0, 0, 1);
    ticks(60);
    step(1, 0, 0, 0, 1);
    check("s6_dead", int'(dut_over[0]), 1);
    do_reset();
    check("s6_dead_health", int'(dut_health[0]), 3);
    check("s6_dead_over", int'(dut_over[0]), 0);
    check("s6_dead_invuln", int'(dut_invuln[0]), 0);
    check("s6_dead_blink", int'(dut_blink[0]), 0);

    // Random stimulus, checked every cycle against the model
    for (int n = 0; n < 4000; n++) begin
      step(($urandom % 6) == 0, ($urandom % 8) == 0, ($urandom % 2) == 0,
           ($urandom % 12) == 0, ($urandom % 400) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/health_controller.md
# health_controller

Player health state machine feeding the health-bar renderer: it owns `present_health`, applies damage from the collision logic, grants post-hit invulnerability, handles heal pickups and slow regeneration, and flags game over. It sits directly upstream of the health-bar pixel stage. That stage compares `present_health` against the bar thresholds 1, 2 and 3. The `blink` output lets the renderer flash the bar during invulnerability.

## Interface
Parameters:
- `MAX_HEALTH`, default 3: full health value; legal range 1..15.
- `INVULN_FRAMES`, default 60: frames of invulnerability after a non-fatal hit; legal range 1..255.
- `REGEN_FRAMES`, default 600: consecutive hit-free frames in ALIVE that earn +1 health; legal range 1..1023.

Ports:
- `clk`  in  1  system clock, shared with the VGA timing logic.
- `rst`  in  1  reset, synchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `hit`  in  1  one-cycle damage pulse from the collision logic.
- `heal`  in  1  one-cycle heal-pickup pulse.
- `restart`  in  1  one-cycle pulse; leaves DEAD.
- `present_health`  out  4  current health, 0..MAX_HEALTH.
- `invuln`  out  1  high while in INVULN.
- `blink`  out  1  bar-flash phase; valid only while `invuln`=1.
- `hit_ack`  out  1  one-cycle pulse for each hit that was applied.
- `game_over`  out  1  high while in DEAD.

## Operation
- All outputs are registered.
- Reset: on a `clk` edge with `rst`=0, the block goes to state ALIVE and sets:
  - `present_health`=MAX_HEALTH
  - `invuln`=0, `blink`=0, `hit_ack`=0, `game_over`=0
  - invulnerability counter=0, regen counter=0
- Reset has priority over every other input and aborts any state, including mid-INVULN and DEAD.
- States are ALIVE, INVULN and DEAD.
- ALIVE:
  - `hit`: health decrements by 1 and `hit_ack` pulses.
    - New health 0 → DEAD.
    - Otherwise → INVULN, invulnerability counter loads INVULN_FRAMES, regen counter clears.
  - `heal` without `hit`: health increments by 1, saturating at MAX_HEALTH.
  - `hit` and `heal` in the same cycle: only the hit is applied; the heal is dropped.
  - `frame_tick` without `hit`: regen counter increments.
    - When it reaches REGEN_FRAMES it clears to 0, and health increments by 1 if below MAX_HEALTH.
    - At MAX_HEALTH the counter still wraps; health does not change.
  - `heal` and regen completing in the same cycle: health increases by 1 total (saturating).
  - A heal pickup does not clear the regen counter.
- INVULN:
  - `hit` is ignored: no `hit_ack`, no decrement.
  - `heal`: health increments by 1, saturating at MAX_HEALTH.
  - Regen counter is frozen at 0.
  - `frame_tick`: invulnerability counter decrements.
    - A tick that finds the counter at 1 moves to ALIVE, with counter=0 and `invuln`=0.
  - `blink` equals bit 3 of the invulnerability counter, so it toggles every 8 frames.
- DEAD:
  - `present_health`=0, `game_over`=1.
  - `hit`, `heal` and `frame_tick` are ignored.
  - `restart` → ALIVE with the full reset values applied (except that `rst` is not involved).
- `restart` outside DEAD is ignored.
- Arithmetic:
  - Health is 4 bits.
  - The decrement occurs only in ALIVE. Because the transition to DEAD happens at 0, health never underflows.
  - Invulnerability counter is 8 bits; regen counter is 10 bits.

## Timing
- `hit` sampled at edge N:
  - `present_health`, `hit_ack`, `invuln` and `game_over` update at edge N (visible in cycle N+1).
  - `hit_ack` is high for exactly one cycle.
- Invulnerability duration is exactly INVULN_FRAMES `frame_tick` pulses, counted after the hit cycle.
  - A `frame_tick` coincident with the hit does not decrement the counter.
- `heal` and `restart` take effect with the same 1-cycle latency.
- The input pulses are single-cycle. A level held high on `hit` or `heal` is treated as one event per cycle and is not edge-detected.
- The downstream renderer samples `present_health` at any time. The value changes only at `clk` edges and is always within 0..MAX_HEALTH.

## Test plan
Scenarios 1–4 and 6 use defaults; scenario 5 overrides INVULN_FRAMES=2 and REGEN_FRAMES=3.
1. Release reset, pulse `hit` → `present_health` goes 3→2; `hit_ack` high for 1 cycle; `invuln`=1; 60 `frame_tick` pulses later `invuln`=0.
2. In INVULN, pulse `hit` 5 times → health stays 2 and `hit_ack` never asserts. After INVULN ends, one `hit` → health 1.
3. Health 1 in ALIVE, pulse `hit` → health 0 and `game_over`=1. Then `heal`, `hit`, `frame_tick` → no change. Then `restart` → health 3, `game_over`=0.
4. Health 2 in ALIVE, `hit` and `heal` in the same cycle → health 1 and state INVULN. At health 3, a `heal` → stays 3.
5. With the overrides, health 2 after INVULN, 3 hit-free ticks → health 3. A hit after 2 ticks clears the regen counter, so no regen occurs.
6. Drive `rst`=0 mid-INVULN (counter 30) and mid-DEAD → next cycle health=3, `invuln`=0, `game_over`=0, `blink`=0.
